// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller request port among NUM_PORTS
// requesters; an in-order tag FIFO steers each returned read word to its issuer.

module sdram_port_arbiter_lane #(
    parameter int BE_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_rd,
    input  logic [BE_W-1:0] i_wr,
    input  logic            i_fifo_full,
    input  logic            i_granted,
    input  logic            i_mem_rdy,
    input  logic            i_rsp_hit,
    output logic            o_wr_any,
    output logic            o_eligible,
    output logic            o_rdy,
    output logic            o_rvalid
);
    assign o_wr_any   = |i_wr;
    // A full tag FIFO only holds back reads; writes never need a tag.
    assign o_eligible = o_wr_any | (i_rd & ~i_fifo_full);
    assign o_rdy      = i_granted & i_mem_rdy;
    assign o_rvalid   = i_rsp_hit;

    a_rd_wr_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_rd && o_wr_any));
endmodule

module sdram_port_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_req_wdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] i_req_wr,
    input  logic [NUM_PORTS-1:0]             i_req_rd,
    output logic [NUM_PORTS-1:0]             o_req_rdy,
    output logic [NUM_PORTS-1:0]             o_req_rvalid,
    output logic [DATA_WIDTH-1:0]            o_req_rdata,
    output logic [ADDR_WIDTH-1:0]            o_mem_addr,
    output logic [DATA_WIDTH-1:0]            o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]          o_mem_wr,
    output logic                             o_mem_rd,
    input  logic                             i_mem_rdy,
    input  logic                             i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]            i_mem_rdata,
    output logic                             o_rsp_err
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // MAX_OUTSTANDING is a power of two >= 2 so the pointers wrap naturally.
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       wr;
        logic                  rd;
    } mem_req_t;

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_wdata;
    logic [NUM_PORTS-1:0][BE_W-1:0]       w_wr;

    assign w_addr  = i_req_addr;
    assign w_wdata = i_req_wdata;
    assign w_wr    = i_req_wr;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_grant, w_grant_nxt;
    logic [PW-1:0]     r_last, w_last_nxt;
    logic [PW-1:0]     w_sel;
    logic              w_found;
    int                w_idx;
    mem_req_t          w_req;

    logic [PW-1:0]     r_tag [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic              w_push, w_pop, w_full;

    logic [NUM_PORTS-1:0] w_wr_any, w_eligible, w_granted, w_rsp_hit;

    assign w_full = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_pop  = i_mem_rvalid && (r_count != '0);
    assign w_push = (r_state == S_GRANT) && i_mem_rdy && w_req.rd;

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_lane
            assign w_granted[g] = (r_state == S_GRANT) && (r_grant == PW'(g));
            assign w_rsp_hit[g] = w_pop && (r_tag[r_rptr] == PW'(g));

            sdram_port_arbiter_lane #(.BE_W(BE_W)) u_lane (
                .i_clk       (i_clk),
                .i_rst_n     (i_rst_n),
                .i_rd        (i_req_rd[g]),
                .i_wr        (w_wr[g]),
                .i_fifo_full (w_full),
                .i_granted   (w_granted[g]),
                .i_mem_rdy   (i_mem_rdy),
                .i_rsp_hit   (w_rsp_hit[g]),
                .o_wr_any    (w_wr_any[g]),
                .o_eligible  (w_eligible[g]),
                .o_rdy       (o_req_rdy[g]),
                .o_rvalid    (o_req_rvalid[g])
            );
        end
    endgenerate

    // Round-robin: first eligible port after the last one granted.
    always_comb begin
        w_sel   = r_last;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx = (int'(r_last) + k) % NUM_PORTS;
            if (!w_found && w_eligible[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = PW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_req       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_sel;
                    w_last_nxt  = w_sel;
                end
            end
            S_GRANT: begin
                w_req.addr  = w_addr[r_grant];
                w_req.wdata = w_wdata[r_grant];
                w_req.wr    = w_wr[r_grant];
                // A read paired with a write is dropped; the write goes through.
                w_req.rd    = i_req_rd[r_grant] & ~w_wr_any[r_grant];
                if (i_mem_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= PW'(NUM_PORTS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_mem_rvalid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_tag[r_wptr] <= r_grant;
        end
    end

    assign o_mem_addr  = w_req.addr;
    assign o_mem_wdata = w_req.wdata;
    assign o_mem_wr    = w_req.wr;
    assign o_mem_rd    = w_req.rd;
    assign o_req_rdata = i_mem_rdata;
    assign o_rsp_err   = r_err;
endmodule
